pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 245 ++++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time/duty capture with restoring divider; optional PWM_CAPTURE_GLITCH_FILTER_EN
module pwm_capture #(
    parameter int CLK_FRE = 27_000_000,
    parameter int CNT_W   = 16,
    parameter int DUTY_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              meas_valid,
    output logic              timeout,
    output logic              meas_err
);

    localparam int P_W  = CNT_W + DUTY_W;
    localparam int DC_W = $clog2(DUTY_W + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DUTY_W-1:0] DUTY_FS  = '1;
    localparam logic [DC_W-1:0]   DIV_LAST = DC_W'(DUTY_W - 1);
    localparam logic [DC_W-1:0]   DIV_DONE = DC_W'(DUTY_W);

    // CLK_FRE only documents the clock rate; a non-positive value marks itself here
    if (CLK_FRE < 1) begin : g_clk_fre_invalid
    end

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DIVIDE
    } state_t;

    state_t state;
    state_t state_next;

    logic sync_a;
    logic sync_b;
    logic level;
    logic level_d;
    logic rise;

    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] high_cnt;

    logic cnt_load;
    logic div_start;
    logic div_last;
    logic tmo_hit;

    logic [P_W-1:0]    product;
    logic [CNT_W-1:0]  div_rem;
    logic [DUTY_W-1:0] div_low;
    logic [CNT_W-1:0]  div_den;
    logic [CNT_W-1:0]  div_hi;
    logic [DUTY_W-1:0] div_quo;
    logic [DC_W-1:0]   div_cnt;
    logic [CNT_W:0]    trial;
    logic              q_bit;
    logic [CNT_W-1:0]  rem_next;

    // two-flop synchronizer for the asynchronous PWM input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= pwm_in;
            sync_b <= sync_a;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt_q;
    logic       agree;

    // level follows the input only once three consecutive samples agree
    assign agree = (sync_b == hist[0]) && (sync_b == hist[1]);
    assign level = agree ? sync_b : filt_q;

    // sample history and held filtered level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist   <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist   <= {hist[0], sync_b};
            filt_q <= level;
        end
    end
`else
    assign level = sync_b;
`endif

    // previous level sample for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state and per-cycle control strobes
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        div_start  = 1'b0;
        div_last   = 1'b0;
        tmo_hit    = 1'b0;
        meas_err   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MEASURE;
                    cnt_load   = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    state_next = DIVIDE;
                    cnt_load   = 1'b1;
                    div_start  = 1'b1;
                end else if (per_cnt == CNT_MAX) begin
                    state_next = IDLE;
                    tmo_hit    = 1'b1;
                end
            end
            DIVIDE: begin
                // an edge here means the period is too short; restart counting,
                // but let the running division finish
                if (rise) begin
                    cnt_load = 1'b1;
                    meas_err = 1'b1;
                end
                if (div_cnt == DIV_LAST) begin
                    div_last = 1'b1;
                end
                // one extra cycle after the last quotient bit, so the result
                // is presented before counting resumes in MEASURE
                if (div_cnt == DIV_DONE) begin
                    state_next = MEASURE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // period and high-time counters; saturate so a stuck input cannot wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt  <= '0;
            high_cnt <= '0;
        end else if (cnt_load) begin
            per_cnt  <= CNT_ONE;
            high_cnt <= CNT_ONE;
        end else if (state != IDLE) begin
            if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_ONE;
            end
            if (level && (high_cnt != CNT_MAX)) begin
                high_cnt <= high_cnt + CNT_ONE;
            end
        end
    end

    // scaled dividend: high_time * full-scale duty
    assign product = P_W'(high_cnt) * P_W'(DUTY_FS);

    // restoring step: the upper product bits are already below the divisor
    // because high_time <= period, so only DUTY_W bits need shifting in
    assign trial    = {div_rem, div_low[DUTY_W-1]};
    assign q_bit    = (trial >= {1'b0, div_den});
    assign rem_next = q_bit ? CNT_W'(trial - {1'b0, div_den}) : trial[CNT_W-1:0];

    // divider registers; loaded on the measuring edge, one quotient bit per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_rem <= '0;
            div_low <= '0;
            div_den <= '0;
            div_hi  <= '0;
            div_quo <= '0;
            div_cnt <= '0;
        end else if (div_start) begin
            div_rem <= product[P_W-1:DUTY_W];
            div_low <= product[DUTY_W-1:0];
            div_den <= per_cnt;
            div_hi  <= high_cnt;
            div_quo <= '0;
            div_cnt <= '0;
        end else if ((state == DIVIDE) && (div_cnt != DIV_DONE)) begin
            div_rem <= rem_next;
            div_low <= div_low << 1;
            div_quo <= {div_quo[DUTY_W-2:0], q_bit};
            div_cnt <= div_cnt + DC_W'(1);
        end
    end

    // result registers, valid pulse and timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty       <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (rise) begin
                timeout <= 1'b0;
            end
            if (div_last) begin
                duty       <= {div_quo[DUTY_W-2:0], q_bit};
                period     <= div_den;
                high_time  <= div_hi;
                meas_valid <= 1'b1;
            end else if (tmo_hit) begin
                duty       <= level ? DUTY_FS : '0;
                period     <= '0;
                high_time  <= '0;
                meas_valid <= 1'b1;
                timeout    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - table-driven bench for pwm_capture
module tb_pwm_capture;

    localparam int CNT_W  = 16;
    localparam int DUTY_W = 10;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int SYNC_LAT = 4;
`else
    localparam int SYNC_LAT = 2;
`endif
    localparam int LAT     = SYNC_LAT + DUTY_W + 1;
    localparam int TMO_LAT = SYNC_LAT + 65536;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pwm_in = 1'b0;
    logic [DUTY_W-1:0] duty;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic              meas_valid;
    logic              timeout;
    logic              meas_err;

    pwm_capture #(
        .CLK_FRE (27_000_000),
        .CNT_W   (CNT_W),
        .DUTY_W  (DUTY_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .meas_err   (meas_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int per;
        int hi;
        int duty;
    } rec_t;

    typedef struct {
        int per;
        int hi;
        int edges;
        int n_valid;
        int n_err;
        int duty;
    } vec_t;

    rec_t vq[$];
    int   eq[$];
    int   err_pulses = 0;
    int   x_seen = 0;
    int   total = 0;
    int   bad = 0;

    always @(negedge clk) begin
        if (!rst) begin
            rec_t r;
            if ($isunknown({duty, period, high_time, meas_valid, timeout, meas_err})) x_seen++;
            if (meas_valid) begin
                r.c    = cyc;
                r.per  = int'(period);
                r.hi   = int'(high_time);
                r.duty = int'(duty);
                vq.push_back(r);
            end
            if (meas_err) err_pulses++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = v;
            if (v && (i == 0)) eq.push_back(cyc);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b0, 3);
        vq.delete();
        eq.delete();
        err_pulses = 0;
    endtask

    task automatic run_pwm(input int per, input int hi, input int edges);
        for (int e = 0; e < edges; e++) begin
            tick(1'b1, hi);
            tick(1'b0, per - hi);
        end
        tick(1'b0, 30);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   n;
        int   c0;

        vecs[0] = '{100, 25, 4, 3, 0, 255};
        vecs[1] = '{50, 49, 3, 2, 0, 1002};
        vecs[2] = '{12, 1, 4, 3, 0, 85};
        vecs[3] = '{200, 100, 2, 1, 0, 511};
        vecs[4] = '{1000, 999, 2, 1, 0, 1021};
        vecs[5] = '{37, 5, 3, 2, 0, 138};
        vecs[6] = '{13, 12, 3, 2, 0, 944};
        vecs[7] = '{8, 3, 9, 4, 4, 383};
        vecs[8] = '{11, 2, 5, 2, 2, 186};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst duty", duty, 0);
        check("rst period", period, 0);
        check("rst high_time", high_time, 0);
        check("rst meas_valid", meas_valid, 0);
        check("rst timeout", timeout, 0);
        check("rst meas_err", meas_err, 0);

        // table-driven periodic waveforms
        for (int v = 0; v < 9; v++) begin
            do_reset();
            run_pwm(vecs[v].per, vecs[v].hi, vecs[v].edges);
            check($sformatf("v%0d valid count", v), vq.size(), vecs[v].n_valid);
            check($sformatf("v%0d err count", v), err_pulses, vecs[v].n_err);
            for (int k = 0; k < vq.size(); k++) begin
                check($sformatf("v%0d[%0d] period", v, k), vq[k].per, vecs[v].per);
                check($sformatf("v%0d[%0d] high_time", v, k), vq[k].hi, vecs[v].hi);
                check($sformatf("v%0d[%0d] duty", v, k), vq[k].duty, vecs[v].duty);
                if ((vecs[v].n_err == 0) && (k + 1 < eq.size()))
                    check($sformatf("v%0d[%0d] latency", v, k), vq[k].c - eq[k + 1], LAT);
            end
            check($sformatf("v%0d held period", v), period, vecs[v].per);
            check($sformatf("v%0d held duty", v), duty, vecs[v].duty);
            check($sformatf("v%0d timeout", v), timeout, 0);
        end

        // reset in the middle of a division
        do_reset();
        tick(1'b1, 25); tick(1'b0, 75);
        tick(1'b1, 25); tick(1'b0, 75);
        check("pre-rst period", period, 100);
        tick(1'b1, 5);
        rst = 1'b1;
        pwm_in = 1'b0;
        #1;
        check("async rst duty", duty, 0);
        check("async rst period", period, 0);
        check("async rst high_time", high_time, 0);
        check("async rst meas_valid", meas_valid, 0);
        tick(1'b0, 2);
        rst = 1'b0;
        vq.delete();
        eq.delete();
        tick(1'b0, 30);
        check("aborted div valid", vq.size(), 0);
        tick(1'b1, 25); tick(1'b0, 75);
        check("arm edge valid", vq.size(), 0);
        tick(1'b1, 25); tick(1'b0, 75);
        check("post-rst valid count", vq.size(), 1);
        if (vq.size() == 1) begin
            check("post-rst period", vq[0].per, 100);
            check("post-rst duty", vq[0].duty, 255);
            check("post-rst latency", vq[0].c - eq[1], LAT);
        end

        // glitch in a long low phase
        do_reset();
        tick(1'b1, 100); tick(1'b0, 50); tick(1'b1, 1); tick(1'b0, 149);
        tick(1'b1, 10); tick(1'b0, 30);
        check("glitch err", err_pulses, 0);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        check("glitch valid count", vq.size(), 1);
        if (vq.size() == 1) begin
            check("glitch period", vq[0].per, 300);
            check("glitch high", vq[0].hi, 100);
            check("glitch duty", vq[0].duty, 341);
        end
`else
        check("glitch valid count", vq.size(), 2);
        if (vq.size() == 2) begin
            check("glitch p0", vq[0].per, 150);
            check("glitch h0", vq[0].hi, 100);
            check("glitch d0", vq[0].duty, 682);
            check("glitch p1", vq[1].per, 150);
            check("glitch h1", vq[1].hi, 1);
            check("glitch d1", vq[1].duty, 6);
        end
`endif

        // input stuck high after one edge
        do_reset();
        c0 = cyc;
        tick(1'b1, 1);
        n = 0;
        while ((vq.size() == 0) && (n < 70000)) begin
            tick(1'b1, 1);
            n++;
        end
        check("timeout valid seen", vq.size(), 1);
        if (vq.size() == 1) begin
            check("timeout latency", vq[0].c - c0, TMO_LAT);
            check("timeout duty", vq[0].duty, 1023);
            check("timeout period", vq[0].per, 0);
            check("timeout high", vq[0].hi, 0);
        end
        check("timeout flag", timeout, 1);
        tick(1'b1, 5);
        check("timeout single pulse", vq.size(), 1);
        tick(1'b0, 5);
        check("timeout held", timeout, 1);
        tick(1'b1, 4);
        check("timeout cleared", timeout, 0);
        check("re-arm no valid", vq.size(), 1);

        check("no X on outputs", x_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
